// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - RGB444 camera byte-pair capture into a linear frame buffer write port
//
// Ports:
//   clk        camera pixel clock, all logic on its rising edge
//   rstn       asynchronous active-low reset
//   cam_vsynk  camera VSYNC, high during vertical blank
//   cam_href   camera HREF, high while a line byte is on cam_data
//   cam_data   camera byte bus, two bytes per RGB444 pixel
//   WriteEn    one-cycle frame-buffer write strobe
//   WriteAdd   linear pixel address (line*H_ACTIVE + pixel), valid with WriteEn
//   WriteData  pixel {R[3:0],G[3:0],B[3:0]}, valid with WriteEn
//   FrameDone  one-cycle pulse when a complete, error-free frame closes
//   LineErr    per-frame sticky flag: some line length differed from H_ACTIVE
//   FrameErr   per-frame sticky flag: wrong pixel total or address overflow

module cam_pixel_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cam_vsynk,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        WriteEn,
    output logic [18:0] WriteAdd,
    output logic [11:0] WriteData,
    output logic        FrameDone,
    output logic        LineErr,
    output logic        FrameErr
);

    // Address counter holds H_ACTIVE*V_ACTIVE (up to 2^19), so it needs 20 bits.
    localparam logic [19:0] TOTAL_PIX = 20'(H_ACTIVE * V_ACTIVE);

    // Line counter saturates one past H_ACTIVE so an over-long line still mismatches.
    localparam int              LC_W     = $clog2(H_ACTIVE + 2);
    localparam logic [LC_W-1:0] LINE_LEN = LC_W'(H_ACTIVE);
    localparam logic [LC_W-1:0] LINE_SAT = LC_W'(H_ACTIVE + 1);

    typedef enum logic [1:0] {
        WAIT_SYNC,
        BLANK,
        LINE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Registered camera pins and one-cycle-delayed copies for edge detection
    logic       vs_r;
    logic       vs_d;
    logic       hr_r;
    logic       hr_d;
    logic [7:0] data_r;

    logic            phase_q;
    logic [3:0]      red_q;
    logic [19:0]     pix_addr_q;
    logic [LC_W-1:0] line_cnt_q;
    logic            clr_pend_q;

    logic vs_rise;
    logic hr_rise;
    logic hr_fall;
    logic byte_valid;
    logic cur_phase;
    logic pixel_done;
    logic addr_full;
    logic do_write;
    logic line_end;
    logic frame_eval;
    logic frame_ok;

    assign vs_rise = vs_r & ~vs_d;
    assign hr_rise = hr_r & ~hr_d;
    assign hr_fall = ~hr_r & hr_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vs_r   <= 1'b0;
            vs_d   <= 1'b0;
            hr_r   <= 1'b0;
            hr_d   <= 1'b0;
            data_r <= 8'd0;
        end else begin
            vs_r   <= cam_vsynk;
            vs_d   <= vs_r;
            hr_r   <= cam_href;
            hr_d   <= hr_r;
            data_r <= cam_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= WAIT_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_valid = 1'b0;
        line_end   = 1'b0;
        // The byte that produces the href rising edge is always the first (phase 0) byte.
        cur_phase  = hr_rise ? 1'b0 : phase_q;

        case (state_q)
            WAIT_SYNC: begin
                state_d = WAIT_SYNC;
            end
            BLANK: begin
                // The first byte of a line arrives in the same cycle as the BLANK->LINE move.
                if (hr_rise && !vs_r) begin
                    state_d    = LINE;
                    byte_valid = 1'b1;
                end
            end
            LINE: begin
                if (hr_fall) begin
                    state_d  = BLANK;
                    line_end = 1'b1;
                end else begin
                    byte_valid = hr_r & ~vs_r;
                end
            end
            default: begin
                state_d = WAIT_SYNC;
            end
        endcase

        // A vsync rise restarts the frame from any state and overrides line handling.
        if (vs_rise) begin
            state_d    = BLANK;
            byte_valid = 1'b0;
            line_end   = 1'b0;
        end

        frame_eval = vs_rise && (state_q != WAIT_SYNC);
        frame_ok   = (pix_addr_q == TOTAL_PIX) && !LineErr && !FrameErr;
        pixel_done = byte_valid && cur_phase;
        addr_full  = (pix_addr_q >= TOTAL_PIX);
        do_write   = pixel_done && !addr_full;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_q    <= 1'b0;
            red_q      <= 4'd0;
            pix_addr_q <= 20'd0;
            line_cnt_q <= '0;
            clr_pend_q <= 1'b0;
            WriteEn    <= 1'b0;
            WriteAdd   <= 19'd0;
            WriteData  <= 12'd0;
            FrameDone  <= 1'b0;
            LineErr    <= 1'b0;
            FrameErr   <= 1'b0;
        end else begin
            WriteEn    <= do_write;
            FrameDone  <= frame_eval && frame_ok;
            // Error flags live for exactly one cycle past the frame evaluation.
            clr_pend_q <= frame_eval;

            if (vs_rise) begin
                phase_q <= 1'b0;
            end else if (byte_valid) begin
                phase_q <= ~cur_phase;
            end else if (hr_rise) begin
                phase_q <= 1'b0;
            end

            if (byte_valid && !cur_phase) begin
                red_q <= data_r[3:0];
            end

            if (vs_rise) begin
                pix_addr_q <= 20'd0;
            end else if (do_write) begin
                pix_addr_q <= pix_addr_q + 20'd1;
            end

            if (do_write) begin
                WriteAdd  <= pix_addr_q[18:0];
                WriteData <= {red_q, data_r};
            end

            // Overflowed pixels still count toward the line length.
            if (hr_rise) begin
                line_cnt_q <= '0;
            end else if (pixel_done && (line_cnt_q != LINE_SAT)) begin
                line_cnt_q <= line_cnt_q + LC_W'(1);
            end

            if (clr_pend_q) begin
                LineErr <= 1'b0;
            end else if (line_end && (line_cnt_q != LINE_LEN)) begin
                LineErr <= 1'b1;
            end

            if (clr_pend_q) begin
                FrameErr <= 1'b0;
            end else if ((frame_eval && !frame_ok) || (pixel_done && addr_full)) begin
                FrameErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - randomized self-checking bench for cam_pixel_capture

module tb_cam_pixel_capture;

    localparam int H     = 8;
    localparam int V     = 4;
    localparam int TOTAL = H * V;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cam_vsynk;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        WriteEn;
    logic [18:0] WriteAdd;
    logic [11:0] WriteData;
    logic        FrameDone;
    logic        LineErr;
    logic        FrameErr;

    cam_pixel_capture #(
        .H_ACTIVE(H),
        .V_ACTIVE(V)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cam_vsynk (cam_vsynk),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .WriteEn   (WriteEn),
        .WriteAdd  (WriteAdd),
        .WriteData (WriteData),
        .FrameDone (FrameDone),
        .LineErr   (LineErr),
        .FrameErr  (FrameErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] addr;
        logic [11:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    int n_checks  = 0;
    int n_fail    = 0;
    int done_seen = 0;
    int done_exp  = 0;
    int cyc       = 0;

    // Reference frame model
    int m_addr  = 0;
    bit m_armed = 1'b0;
    bit m_le    = 1'b0;
    bit m_fe    = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn === 1'b1 && WriteEn === 1'b1) begin
            check_eq("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("write_addr", 32'(WriteAdd), 32'(mon_e.addr));
                check_eq("write_data", 32'(WriteData), 32'(mon_e.data));
                check_eq("write_cycle", cyc, mon_e.cyc);
            end
        end
        if (FrameDone === 1'b1) done_seen++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t reached limit %0t", $time, 1000000);
        $fatal(1);
    end

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        cam_href = 1'b1;
        cam_data = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cam_href = 1'b0;
            cam_data = 8'($urandom);
        end
    endtask

    // Called right after the second byte of a pixel is put on the pins.
    task automatic model_pixel(input logic [7:0] b0, input logic [7:0] b1);
        wr_t w;
        if (!m_armed) return;
        if (m_addr < TOTAL) begin
            w.addr = 19'(m_addr);
            w.data = {b0[3:0], b1};
            w.cyc  = cyc + 2;
            exp_q.push_back(w);
            m_addr++;
        end else begin
            m_fe = 1'b1;
        end
    endtask

    task automatic send_line(input int npix, input bit odd);
        logic [7:0] b0;
        logic [7:0] b1;
        for (int i = 0; i < npix; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            drive_byte(b0);
            drive_byte(b1);
            model_pixel(b0, b1);
        end
        if (odd) drive_byte(8'($urandom));
        idle($urandom_range(1, 3));
        if (m_armed && npix != H) m_le = 1'b1;
    endtask

    task automatic send_frame(input int nlines);
        for (int l = 0; l < nlines; l++) send_line(H, 1'b0);
    endtask

    task automatic vsync_pulse(input string tag);
        bit exp_done;
        bit exp_fe;
        bit exp_le;
        repeat (3) @(negedge clk);
        #1;
        check_eq({tag, "_pre_lineerr"}, 32'(LineErr), 32'(m_le));
        check_eq({tag, "_pre_frameerr"}, 32'(FrameErr), 32'(m_fe));
        check_eq({tag, "_pending_writes"}, exp_q.size(), 0);
        exp_done = m_armed && (m_addr == TOTAL) && !m_le && !m_fe;
        exp_fe   = m_armed && !exp_done;
        exp_le   = m_le;
        cam_vsynk = 1'b1;
        repeat (2) @(negedge clk);
        check_eq({tag, "_framedone"}, 32'(FrameDone), 32'(exp_done));
        check_eq({tag, "_frameerr"}, 32'(FrameErr), 32'(exp_fe));
        check_eq({tag, "_lineerr"}, 32'(LineErr), 32'(exp_le));
        if (exp_done) done_exp++;
        @(negedge clk);
        check_eq({tag, "_framedone_pulse"}, 32'(FrameDone), 0);
        check_eq({tag, "_lineerr_clr"}, 32'(LineErr), 0);
        check_eq({tag, "_frameerr_clr"}, 32'(FrameErr), 0);
        // href chatter during vertical blank must be ignored
        repeat ($urandom_range(2, 6)) begin
            @(negedge clk);
            cam_href = 1'($urandom);
            cam_data = 8'($urandom);
        end
        idle(2);
        @(negedge clk);
        cam_vsynk = 1'b0;
        idle(3);
        m_armed = 1'b1;
        m_addr  = 0;
        m_le    = 1'b0;
        m_fe    = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_writeen"}, 32'(WriteEn), 0);
        check_eq({tag, "_writeadd"}, 32'(WriteAdd), 0);
        check_eq({tag, "_writedata"}, 32'(WriteData), 0);
        check_eq({tag, "_framedone"}, 32'(FrameDone), 0);
        check_eq({tag, "_lineerr"}, 32'(LineErr), 0);
        check_eq({tag, "_frameerr"}, 32'(FrameErr), 0);
    endtask

    initial begin
        logic [7:0] b0;
        logic [7:0] b1;
        int nl;
        int np;

        rstn      = 1'b0;
        cam_vsynk = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;

        // Data before the first vsync is discarded; first vsync is exempt
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        vsync_pulse("first_vs");

        send_frame(V);
        vsync_pulse("good0");
        send_frame(V);
        vsync_pulse("good1");

        // Short line with a trailing odd byte
        send_line(H, 1'b0);
        send_line(H - 1, 1'b1);
        send_line(H, 1'b0);
        send_line(H, 1'b0);
        vsync_pulse("short_line");
        send_frame(V);
        vsync_pulse("after_short");

        // Frame restarted part way through
        send_frame(2);
        vsync_pulse("restart");
        send_frame(V);
        vsync_pulse("after_restart");

        // One line too many: writes stop at the last address, which holds
        send_frame(V + 1);
        repeat (3) @(negedge clk);
        #1;
        check_eq("ovf_addr_hold", 32'(WriteAdd), TOTAL - 1);
        check_eq("ovf_frameerr", 32'(FrameErr), 1);
        vsync_pulse("overflow");

        // Reset in the middle of a line
        send_frame(2);
        for (int i = 0; i < 3; i++) begin
            b0 = 8'($urandom);
            b1 = 8'($urandom);
            drive_byte(b0);
            drive_byte(b1);
            model_pixel(b0, b1);
        end
        drive_byte(8'($urandom));
        @(negedge clk);
        #2;
        rstn = 1'b0;
        exp_q.delete();
        m_armed = 1'b0;
        m_addr  = 0;
        m_le    = 1'b0;
        m_fe    = 1'b0;
        #1;
        check_outputs_zero("midline_reset");
        repeat (4) drive_byte(8'($urandom));
        @(negedge clk);
        #2;
        rstn = 1'b1;
        repeat (6) drive_byte(8'($urandom));
        idle(2);
        send_line(H, 1'b0);
        vsync_pulse("post_reset");
        send_frame(V);
        vsync_pulse("after_reset");

        // Randomized frames with occasional bad lines, odd bytes and wrong line counts
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(V - 1, V + 1);
            for (int l = 0; l < nl; l++) begin
                np = ($urandom_range(0, 3) == 0) ? $urandom_range(H - 2, H + 1) : H;
                send_line(np, $urandom_range(0, 4) == 0);
            end
            vsync_pulse("rand");
        end

        repeat (4) @(negedge clk);
        check_eq("done_count", done_seen, done_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_pixel_capture.md
CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, shall set the pixels per camera line.
REQ-002 Parameter V_ACTIVE, default 480, shall set the lines per camera frame; H_ACTIVE*V_ACTIVE shall not exceed 2^19.
REQ-003 clk  input  1  shall be the camera pixel clock; all logic shall sit on its rising edge.
REQ-004 rstn  input  1  shall be the asynchronous active-low reset.
REQ-005 cam_vsynk  input  1  shall be the camera VSYNC; high means vertical blank.
REQ-006 cam_href  input  1  shall be the camera HREF; high means an active line byte.
REQ-007 cam_data  input  8  shall be the camera byte bus, in RGB444 byte pairs.
REQ-008 WriteEn  output  1  shall be a single-cycle frame-buffer write strobe.
REQ-009 WriteAdd  output  19  shall be the linear pixel address, equal to line*H_ACTIVE+pixel.
REQ-010 WriteData  output  12  shall be the pixel, packed {R[3:0],G[3:0],B[3:0]}.
REQ-011 FrameDone  output  1  shall be a one-cycle pulse at the end of a complete, error-free frame.
REQ-012 LineErr  output  1  shall be a sticky flag for a line length other than H_ACTIVE.
REQ-013 FrameErr  output  1  shall be a sticky flag for a pixel count other than H_ACTIVE*V_ACTIVE, or for an address overflow.

Function
REQ-014 cam_vsynk, cam_href and cam_data shall be registered once before any use; all later references mean these registered copies.
REQ-015 Rising edge of vsync is vsync-high now and low one cycle earlier; rising and falling edges of href are defined the same way.
REQ-016 The state machine shall have three states: WAIT_SYNC, BLANK and LINE.
REQ-017 WAIT_SYNC is the reset state; it shall ignore all data and move to BLANK on the first rising edge of vsync.
REQ-018 BLANK shall move to LINE on a rising edge of href while vsync is low.
REQ-019 LINE shall move to BLANK on a falling edge of href.
REQ-020 A rising edge of vsync in any state shall clear the pixel address and the byte phase and force BLANK (frame restart).
REQ-021 The byte phase shall clear on each rising edge of href; in LINE it shall toggle per byte.
REQ-022 Phase 0 shall latch byte[3:0] as R.
REQ-023 Phase 1 shall form WriteData = {R, byte[7:0]}.
REQ-024 WriteEn shall assert one cycle after the phase-1 byte is registered, making the latency 2 clk from pins to WriteEn.
REQ-025 WriteAdd and WriteData shall be valid in the same cycle as WriteEn.
REQ-026 WriteAdd shall increment by 1 after each write; its first write of a frame shall be 0.
REQ-027 If a write would hit an address >= H_ACTIVE*V_ACTIVE, WriteEn shall stay low, the address shall not increment, and FrameErr shall set.
REQ-028 An odd trailing byte at the href falling edge shall be discarded with no write.
REQ-029 A per-line pixel counter shall be compared to H_ACTIVE at each href falling edge; on a mismatch LineErr shall set.
REQ-030 On each vsync rising edge leaving a frame, FrameDone shall pulse one cycle only if: the address equals H_ACTIVE*V_ACTIVE, LineErr=0 and FrameErr=0.
REQ-031 Otherwise FrameErr shall set (the first vsync out of WAIT_SYNC is exempt).
REQ-032 LineErr and FrameErr shall clear on the cycle after the FrameDone evaluation, i.e. they are sticky per frame.
REQ-033 href activity while vsync is high shall be ignored.
REQ-034 Internal counters shall be sized to their maximum values plus 1 and shall never wrap.

Reset
REQ-035 While rstn=0: WriteEn=0, WriteAdd=0, WriteData=0, FrameDone=0, LineErr=0, FrameErr=0, the state shall be WAIT_SYNC, and the phase and counters shall be 0.
REQ-036 A reset asserted mid-line shall abort with no further write; after release, the block shall discard data until a new vsync rising edge.

Verification
REQ-037 Reset, vsync pulse, then a full 640x480 frame of byte pairs (0x0A,0xBC) -> 307200 WriteEn pulses, WriteAdd 0..307199, WriteData=0xABC, FrameDone pulse on the next vsync rise.
REQ-038 Data driven before the first vsync after reset -> no WriteEn; the first write after vsync has WriteAdd=0.
REQ-039 One line of 639 pixels plus an odd byte -> no write for the odd byte, LineErr=1, no FrameDone, FrameErr=1, and both flags clear on the next frame.
REQ-040 vsync rising after line 100 (mid-frame) -> no FrameDone, FrameErr=1, and the next frame's first WriteAdd=0.
REQ-041 481 lines of 640 pixels -> writes stop at WriteAdd=307199, FrameErr=1, and the address holds.
REQ-042 rstn pulsed low during line 5 -> all outputs 0 immediately, and no writes until a vsync rise followed by href.
